mdr_bin2bcd_disp: RTL and testbench
===================================

Name: mdr_bin2bcd_disp

Overview:
- Downstream display stage of the MDR datapath.
- Accepts one signed 16-bit MDR result per start pulse.
- Converts its magnitude to BCD with a sequential double-dabble: one shift per clock, add-3 correction per digit.
- Drives one sign display and N_DIG seven-segment displays, using the team's active-low segment encodings (ZERO..NINE, OFF, SIGN). Displays hold until the next conversion completes.

Parameters:
- W_IN, 16, input data width; also the number of shift cycles.
- N_DIG, 5, number of BCD digits and displays; must satisfy 10^N_DIG > 2^W_IN.
- LZB, 1, leading-zero blanking: 1 = blank leading zero digits, 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  conversion request; sampled only in IDLE.
- data_i  in  W_IN  two's-complement result; sampled in the same cycle start_i is accepted.
- busy_o  out  1  high while in PROCESING or READY.
- done_o  out  1  one-cycle pulse when new display values are valid.
- bcd_o  out  N_DIG*4  registered BCD digits; digit 0 (units) in bits [3:0].
- seg_o  out  N_DIG*7  registered segment codes; digit 0 in bits [6:0].
- seg_sign_o  out  7  SIGN (7'b0111111) if the result is negative, else OFF.

Behaviour:
- Reset (rst=1 at a rising edge, in any state):
  - state=IDLE; busy_o=0, done_o=0, bcd_o=0.
  - Every seg_o digit = OFF (7'b1111111); seg_sign_o=OFF.
  - Shift register and counter cleared; an in-progress conversion is discarded.
- FSM states: IDLE(00), PROCESING(01), READY(10). Encoding 11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - If start_i=1: capture the sign bit data_i[W_IN-1].
  - Capture magnitude = data_i negative ? (~data_i + 1) : data_i, as a W_IN-bit unsigned value. -32768 yields magnitude 32768 with no overflow.
  - Clear the BCD accumulator and counter; go to PROCESING.
- PROCESING, one iteration per cycle:
  - For each BCD digit >= 5, add 3.
  - Then shift the {bcd, magnitude} register left by 1.
  - Increment the counter. After the W_IN-th shift, go to READY.
- READY:
  - Register bcd_o from the accumulator.
  - Register seg_o via a per-digit decode: 0..9 map to ZERO..NINE; any other value maps to OFF.
  - Register seg_sign_o from the captured sign. -0 cannot occur; zero is always positive.
  - Set done_o=1 for exactly one cycle; go to IDLE.
- Leading-zero blanking (LZB=1): a digit above the units digit is OFF if it and all higher digits are zero. The units digit always shows, so the value 0 displays as ZERO. bcd_o is never blanked.
- Latency:
  - start_i high in cycle T.
  - busy_o high in cycles T+1 .. T+W_IN+1.
  - done_o and the new outputs appear in cycle T+W_IN+2 (T+18 at default), with busy_o=0 in that cycle.
  - A new start may be accepted in cycle T+W_IN+2.
- start_i outside IDLE is ignored. It is not queued, and a changing data_i has no effect.
- Outputs change only on the READY edge or on reset; they are stable otherwise.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then start with data_i=0.
   - Before completion: all displays OFF.
   - Cycle T+18: done_o=1, bcd_o=0x00000, digit0=ZERO, digits1-4=OFF, sign=OFF.
2. data_i=12345.
   - bcd_o=0x12345.
   - seg_o digits 4..0 = ONE, TWO, TREE (three), FOUR, FIVE; sign=OFF.
   - done_o in exactly cycle T+18 and lasting one cycle; busy_o high in T+1..T+17.
3. data_i=-1 (0xFFFF), then data_i=-32768 (0x8000).
   - For -1: bcd_o=0x00001, digit0=ONE, digits1-4=OFF, sign=SIGN.
   - For -32768: bcd_o=0x32768, sign=SIGN.
4. data_i=100 with LZB=1.
   - digits = OFF, OFF, ONE, ZERO, ZERO.
   - With LZB=0: ZERO, ZERO, ONE, ZERO, ZERO.
5. Start with 999, then pulse start_i with 555 in cycles T+5 and T+17.
   - Second request ignored; result 999 shown.
   - A start in T+18 converts 555.
6. Start with 4321, assert rst in cycle T+8.
   - Next cycle: IDLE, busy_o=0, all displays OFF, no done_o pulse.
   - A subsequent start with 7 yields digit0=SEVEN.

Source files
------------

// File: rtl/mdr_bin2bcd_disp_if.sv
// Request/result bundle between the MDR datapath and its BCD display stage.
// The master issues conversion requests; the slave returns digits and segments.
interface mdr_bin2bcd_disp_if #(
  parameter int W_IN  = 16,
  parameter int N_DIG = 5
);
  logic                 start_i;
  logic [W_IN-1:0]      data_i;
  logic                 busy_o;
  logic                 done_o;
  logic [N_DIG*4-1:0]   bcd_o;
  logic [N_DIG*7-1:0]   seg_o;
  logic [6:0]           seg_sign_o;

  modport master (
    output start_i, data_i,
    input  busy_o, done_o, bcd_o, seg_o, seg_sign_o
  );

  modport slave (
    input  start_i, data_i,
    output busy_o, done_o, bcd_o, seg_o, seg_sign_o
  );
endinterface

// File: rtl/mdr_bin2bcd_disp.sv
// Signed binary to BCD display stage: sequential double-dabble (one shift per
// clock) driving a sign display and N_DIG active-low seven-segment displays.
module mdr_bin2bcd_disp #(
  parameter int W_IN  = 16,
  parameter int N_DIG = 5,
  parameter bit LZB   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mdr_bin2bcd_disp_if.slave bus
);

  localparam int BCD_W = N_DIG * 4;
  localparam int SEG_W = N_DIG * 7;
  localparam int SHR_W = BCD_W + W_IN;
  localparam int CNT_W = $clog2(W_IN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_IN - 1);
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_SIGN = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PROCESING = 2'b01,
    READY     = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [BCD_W-1:0]   bcd_r;
  logic [W_IN-1:0]    mag_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_r;
  logic               busy_r;
  logic               done_r;
  logic [BCD_W-1:0]   bcd_out_r;
  logic [SEG_W-1:0]   seg_out_r;
  logic [6:0]         sign_seg_r;
  logic [BCD_W-1:0]   bcd_adj_s;
  logic [SHR_W-1:0]   shift_s;
  logic [W_IN-1:0]    mag_in_s;
  logic [SEG_W-1:0]   seg_nxt_s;

  // Active-low segment pattern, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg_decode(input logic [3:0] dig);
    logic [6:0] seg;
    case (dig)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (bus.start_i) state_nxt_s = PROCESING;
        else             state_nxt_s = IDLE;
      end
      PROCESING: begin
        if (cnt_r == CNT_LAST) state_nxt_s = READY;
        else                   state_nxt_s = PROCESING;
      end
      READY:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Two's-complement magnitude; the most negative input maps to 2^(W_IN-1).
  always_comb begin
    mag_in_s = bus.data_i;
    if (bus.data_i[W_IN-1]) mag_in_s = ~bus.data_i + {{(W_IN-1){1'b0}}, 1'b1};
    else                    mag_in_s = bus.data_i;
  end

  // Add-3 correction on every digit that would overflow when doubled.
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      else                         bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
    end
  end

  assign shift_s = {bcd_adj_s, mag_r} << 1;

  // Segment decode with optional leading-zero blanking; units digit always lit.
  always_comb begin
    logic lead_zero;
    logic [3:0] dig;
    seg_nxt_s = {N_DIG{SEG_OFF}};
    lead_zero = 1'b1;
    dig       = 4'd0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      dig       = bcd_r[i*4 +: 4];
      lead_zero = lead_zero & (dig == 4'd0);
      if (LZB && lead_zero && (i != 0)) seg_nxt_s[i*7 +: 7] = SEG_OFF;
      else                              seg_nxt_s[i*7 +: 7] = seg_decode(dig);
    end
  end

  // Conversion datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r      <= '0;
      mag_r      <= '0;
      cnt_r      <= '0;
      sign_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_out_r  <= '0;
      seg_out_r  <= {N_DIG{SEG_OFF}};
      sign_seg_r <= SEG_OFF;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt_s == PROCESING) || (state_nxt_s == READY);
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            sign_r <= bus.data_i[W_IN-1];
            mag_r  <= mag_in_s;
            bcd_r  <= '0;
            cnt_r  <= '0;
          end
        end
        PROCESING: begin
          bcd_r <= shift_s[SHR_W-1:W_IN];
          mag_r <= shift_s[W_IN-1:0];
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        READY: begin
          bcd_out_r  <= bcd_r;
          seg_out_r  <= seg_nxt_s;
          sign_seg_r <= sign_r ? SEG_SIGN : SEG_OFF;
          done_r     <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;
  assign bus.bcd_o      = bcd_out_r;
  assign bus.seg_o      = seg_out_r;
  assign bus.seg_sign_o = sign_seg_r;

endmodule

// File: tb/tb_mdr_bin2bcd_disp.sv
// Scoreboard bench for mdr_bin2bcd_disp: one DUT with leading-zero blanking,
// one without, both fed the same requests.
module tb_mdr_bin2bcd_disp;
  localparam int W_IN  = 16;
  localparam int N_DIG = 5;
  localparam logic [6:0] OFF = 7'h7F;

  typedef struct packed {
    logic [19:0] bcd;
    logic [34:0] seg_lz;
    logic [34:0] seg_nz;
    logic [6:0]  sign;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v = 1'b0;
  logic [15:0] data_v = 16'h0000;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mdr_bin2bcd_disp_if #(.W_IN(W_IN), .N_DIG(N_DIG)) bus_lz ();
  mdr_bin2bcd_disp_if #(.W_IN(W_IN), .N_DIG(N_DIG)) bus_nz ();

  assign bus_lz.start_i = start_v;
  assign bus_lz.data_i  = data_v;
  assign bus_nz.start_i = start_v;
  assign bus_nz.data_i  = data_v;

  mdr_bin2bcd_disp #(.W_IN(W_IN), .N_DIG(N_DIG), .LZB(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .bus(bus_lz));
  mdr_bin2bcd_disp #(.W_IN(W_IN), .N_DIG(N_DIG), .LZB(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .bus(bus_nz));

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return OFF;
    endcase
  endfunction

  // Reference conversion by repeated division.
  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    int v, mag, hi;
    int dg[5];
    v   = int'($signed(d));
    mag = (v < 0) ? -v : v;
    hi  = 0;
    for (int i = 0; i < 5; i++) begin
      dg[i] = mag % 10;
      mag   = mag / 10;
      if (dg[i] != 0) hi = i;
    end
    for (int i = 0; i < 5; i++) begin
      e.bcd[i*4 +: 4]    = 4'(dg[i]);
      e.seg_nz[i*7 +: 7] = ref_seg(dg[i]);
      e.seg_lz[i*7 +: 7] = (i > hi) ? OFF : ref_seg(dg[i]);
    end
    e.sign = (v < 0) ? 7'h3F : OFF;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle (cycle T) and record the expected result.
  task automatic pulse_start(input logic [15:0] d);
    start_v = 1'b1;
    data_v  = d;
    sb.push_back(model(d));
    step();
    start_v = 1'b0;
    data_v  = 16'($urandom);
  endtask

  // Bounded wait for done; lat is the cycle offset from T where done appeared.
  task automatic wait_done(input int from, output int lat, output bit busy_ok);
    lat = from;
    busy_ok = 1'b1;
    while (bus_lz.done_o !== 1'b1 && lat < 40) begin
      if (bus_lz.busy_o !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({bus_lz.busy_o, bus_lz.done_o, bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o, bus_nz.seg_o}
        !== {1'b0, 1'b0, 20'h0, {5{OFF}}, OFF, {5{OFF}}})
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h seg=%h sign=%h want 0 0 00000 all OFF",
               bus_lz.busy_o, bus_lz.done_o, bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o);
    else n_pass++;
  endtask

  task automatic test_zero();
    int lat; bit busy_ok; exp_t e;
    pulse_start(16'd0);
    repeat (4) step();
    n_checks++;
    if ({bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o, bus_lz.done_o} !== {{10{OFF}}, OFF, 1'b0})
      $display("FAIL zero_pending_off: got seg=%h sign=%h done=%b want all OFF, done 0",
               bus_lz.seg_o, bus_lz.seg_sign_o, bus_lz.done_o);
    else n_pass++;
    wait_done(5, lat, busy_ok);
    e = pop_exp();
    n_checks++;
    if (lat != 18) $display("FAIL zero_latency: got %0d want 18", lat);
    else n_pass++;
    n_checks++;
    if ({bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e)
      $display("FAIL zero_result: got %h want %h",
               {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o}, e);
    else n_pass++;
    n_checks++;
    if ({bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o} !== {20'h0, {4{OFF}}, 7'h40, OFF})
      $display("FAIL zero_display: got bcd=%h seg=%h sign=%h", bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o);
    else n_pass++;
  endtask

  task automatic test_12345();
    int lat; bit busy_ok; exp_t e;
    pulse_start(16'd12345);
    wait_done(1, lat, busy_ok);
    e = pop_exp();
    n_checks++;
    if (lat != 18 || !busy_ok || bus_lz.busy_o !== 1'b0)
      $display("FAIL 12345_timing: got lat=%0d busy_ok=%0d busy_at_done=%b want 18 1 0",
               lat, busy_ok, bus_lz.busy_o);
    else n_pass++;
    n_checks++;
    if ({bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o}
        !== {20'h12345, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, OFF})
      $display("FAIL 12345_display: got bcd=%h seg=%h sign=%h", bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o);
    else n_pass++;
    n_checks++;
    if ({bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e)
      $display("FAIL 12345_result: got %h want %h",
               {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o}, e);
    else n_pass++;
    step();
    n_checks++;
    if (bus_lz.done_o !== 1'b0) $display("FAIL 12345_done_width: got done=%b want 0", bus_lz.done_o);
    else n_pass++;
  endtask

  task automatic test_negative();
    int lat; bit busy_ok; exp_t e;
    logic [15:0] vals[2];
    logic [19:0] bcds[2];
    vals = '{16'hFFFF, 16'h8000};
    bcds = '{20'h00001, 20'h32768};
    for (int k = 0; k < 2; k++) begin
      pulse_start(vals[k]);
      wait_done(1, lat, busy_ok);
      e = pop_exp();
      n_checks++;
      if (lat != 18) $display("FAIL neg_latency_%h: got %0d want 18", vals[k], lat);
      else n_pass++;
      n_checks++;
      if ({bus_lz.bcd_o, bus_lz.seg_sign_o} !== {bcds[k], 7'h3F})
        $display("FAIL neg_value_%h: got bcd=%h sign=%h want %h 3f", vals[k], bus_lz.bcd_o, bus_lz.seg_sign_o, bcds[k]);
      else n_pass++;
      n_checks++;
      if ({bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e)
        $display("FAIL neg_result_%h: got %h want %h", vals[k],
                 {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o}, e);
      else n_pass++;
    end
  endtask

  task automatic test_lzb();
    int lat; bit busy_ok; exp_t e;
    pulse_start(16'd100);
    wait_done(1, lat, busy_ok);
    e = pop_exp();
    n_checks++;
    if ({bus_lz.seg_o, bus_nz.seg_o} !== {OFF, OFF, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40})
      $display("FAIL lzb_100: got lz=%h nz=%h", bus_lz.seg_o, bus_nz.seg_o);
    else n_pass++;
    n_checks++;
    if ({bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e || bus_nz.bcd_o !== 20'h00100)
      $display("FAIL lzb_result: got %h want %h", {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o}, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; bit busy_ok; exp_t e;
    pulse_start(16'd999);
    repeat (4) step();
    start_v = 1'b1; data_v = 16'd555;
    step();
    start_v = 1'b0;
    repeat (11) step();
    start_v = 1'b1; data_v = 16'd555;
    step();
    e = pop_exp();
    n_checks++;
    if (bus_lz.done_o !== 1'b1 || {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e)
      $display("FAIL ignore_start_999: got done=%b bcd=%h want done=1 bcd=%h", bus_lz.done_o, bus_lz.bcd_o, e.bcd);
    else n_pass++;
    pulse_start(16'd555);
    wait_done(1, lat, busy_ok);
    e = pop_exp();
    n_checks++;
    if (lat != 18 || {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e)
      $display("FAIL b2b_555: got lat=%0d bcd=%h want 18 %h", lat, bus_lz.bcd_o, e.bcd);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat; bit busy_ok; bit seen; exp_t e;
    pulse_start(16'd4321);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    n_checks++;
    if ({bus_lz.busy_o, bus_lz.done_o, bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o, bus_nz.seg_o}
        !== {1'b0, 1'b0, 20'h0, {5{OFF}}, OFF, {5{OFF}}})
      $display("FAIL abort_state: got busy=%b done=%b bcd=%h seg=%h sign=%h",
               bus_lz.busy_o, bus_lz.done_o, bus_lz.bcd_o, bus_lz.seg_o, bus_lz.seg_sign_o);
    else n_pass++;
    seen = 1'b0;
    repeat (25) begin
      step();
      if (bus_lz.done_o !== 1'b0 || bus_lz.busy_o !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL abort_no_done: got activity=1 want 0");
    else n_pass++;
    pulse_start(16'd7);
    wait_done(1, lat, busy_ok);
    e = pop_exp();
    n_checks++;
    if (lat != 18 || bus_lz.seg_o[6:0] !== 7'h78 || {bus_lz.bcd_o, bus_lz.seg_o, bus_nz.seg_o, bus_lz.seg_sign_o} !== e)
      $display("FAIL abort_then_7: got lat=%0d seg=%h want 18 %h", lat, bus_lz.seg_o, e.seg_lz);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_12345();
    test_negative();
    test_lzb();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
